// File: rtl/mouse_cmd_pkg.sv
// Shared definitions for the MouseCtl command arbiter: opcodes, FSM states
// and the opcode-to-strobe decode.
package mouse_cmd_pkg;

   localparam int VAL_W = 12;

   localparam logic [2:0] OP_SETMAX_X = 3'd0;
   localparam logic [2:0] OP_SETMAX_Y = 3'd1;
   localparam logic [2:0] OP_SETMIN_X = 3'd2;
   localparam logic [2:0] OP_SETMIN_Y = 3'd3;
   localparam logic [2:0] OP_SET_X    = 3'd4;
   localparam logic [2:0] OP_SET_Y    = 3'd5;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_HOLD  = 2'd2
   } state_t;

   function automatic logic op_legal(input logic [2:0] op);
      return op <= OP_SET_Y;
   endfunction

   // Bit n of the result is the strobe for opcode n; illegal opcodes decode to none.
   function automatic logic [5:0] op_strobe(input logic [2:0] op);
      return op_legal(op) ? 6'(1 << op) : 6'd0;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request above ptr, wrapping.
module rr_arbiter #(
   parameter int N_REQ = 3
) (
   input  logic [N_REQ-1:0] req,
   input  logic [1:0]       ptr,
   output logic [N_REQ-1:0] grant,
   output logic [1:0]       grant_idx,
   output logic             found
);

   int best_d;
   int d;

   // d is the search distance from ptr+1; the smallest distance among valid requests wins.
   always_comb begin
      best_d    = N_REQ;
      d         = 0;
      grant_idx = '0;
      for (int i = 0; i < N_REQ; i++) begin
         d = (i + 2 * N_REQ - 1 - int'(ptr)) % N_REQ;
         if (req[i] && d < best_d) begin
            best_d    = d;
            grant_idx = 2'(i);
         end
      end
      found = best_d < N_REQ;
      grant = '0;
      for (int i = 0; i < N_REQ; i++) begin
         grant[i] = found && (grant_idx == 2'(i));
      end
   end

endmodule

// File: rtl/mouse_cmd_arbiter.sv
// Shares the MouseCtl configuration port between N_REQ requesters: round-robin
// accept, one strobe per legal command, then GAP idle cycles of hold-off.
module mouse_cmd_arbiter #(
   parameter int N_REQ = 3,
   parameter int GAP   = 2,
   parameter int VAL_W = mouse_cmd_pkg::VAL_W
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [N_REQ-1:0]       req_valid,
   input  logic [3*N_REQ-1:0]     req_op,
   input  logic [VAL_W*N_REQ-1:0] req_value,
   output logic [N_REQ-1:0]       req_ready,
   output logic [VAL_W-1:0]       value,
   output logic                   setmax_x,
   output logic                   setmax_y,
   output logic                   setmin_x,
   output logic                   setmin_y,
   output logic                   set_x,
   output logic                   set_y,
   output logic [1:0]             grant_id,
   output logic                   busy,
   output logic                   err_op,
   output mouse_cmd_pkg::state_t  state
);

   import mouse_cmd_pkg::*;

   localparam logic [3:0] GAP_LOAD = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

   logic [1:0]       ptr;
   logic [N_REQ-1:0] win;
   logic [1:0]       win_idx;
   logic             win_found;
   logic [2:0]       win_op;
   logic [VAL_W-1:0] win_value;
   logic [5:0]       strb;
   logic [3:0]       cnt;

   rr_arbiter #(.N_REQ(N_REQ)) u_rr (
      .req       (req_valid),
      .ptr       (ptr),
      .grant     (win),
      .grant_idx (win_idx),
      .found     (win_found)
   );

   // Handshake: a requester holds valid/op/value until it sees ready; the
   // transfer happens on the clock edge where both are high. Ready is only
   // offered in IDLE, to the single round-robin winner.
   assign req_ready = (state == ST_IDLE) ? win : '0;

   always_comb begin
      win_op    = '0;
      win_value = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (win_idx == 2'(i)) begin
            win_op    = req_op[3*i +: 3];
            win_value = req_value[VAL_W*i +: VAL_W];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_IDLE;
         strb     <= '0;
         value    <= '0;
         grant_id <= '0;
         err_op   <= 1'b0;
         cnt      <= '0;
         ptr      <= 2'(N_REQ - 1);
      end else begin
         case (state)
            ST_IDLE: begin
               if (win_found) begin
                  ptr      <= win_idx;
                  grant_id <= win_idx;
                  if (op_legal(win_op)) begin
                     strb  <= op_strobe(win_op);
                     value <= win_value;
                     state <= ST_ISSUE;
                  end else begin
                     err_op <= 1'b1;
                  end
               end
            end
            ST_ISSUE: begin
               strb <= '0;
               if (GAP > 0) begin
                  cnt   <= GAP_LOAD;
                  state <= ST_HOLD;
               end else begin
                  state <= ST_IDLE;
               end
            end
            ST_HOLD: begin
               if (cnt == 4'd0) state <= ST_IDLE;
               else             cnt   <= cnt - 4'd1;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign busy     = (state != ST_IDLE);
   assign setmax_x = strb[OP_SETMAX_X];
   assign setmax_y = strb[OP_SETMAX_Y];
   assign setmin_x = strb[OP_SETMIN_X];
   assign setmin_y = strb[OP_SETMIN_Y];
   assign set_x    = strb[OP_SET_X];
   assign set_y    = strb[OP_SET_Y];

endmodule

// File: tb/tb_mouse_cmd_arbiter.sv
// Bench for mouse_cmd_arbiter: a GAP=2 instance and a GAP=0 instance, each
// compared every cycle against a transaction-level model plus directed literals.
module tb_mouse_cmd_arbiter;

   localparam int N = 3;
   localparam int W = 12;

   logic clk = 1'b0;
   logic rst = 1'b1;

   logic [N-1:0]   rv   [2];
   logic [3*N-1:0] rop  [2];
   logic [W*N-1:0] rval [2];
   wire  [N-1:0]   rdy  [2];
   wire  [W-1:0]   dval [2];
   wire  [5:0]     stb  [2];
   wire  [1:0]     gid  [2];
   wire            dbusy [2];
   wire            derr  [2];
   wire  [1:0]     dstate [2];

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;
   int cyc = 0;
   int lk  = 0;

   // model state per instance
   int m_busy [2];
   int m_ptr  [2];
   int m_gid  [2];
   int m_stb  [2];
   bit m_err  [2];
   logic [W-1:0] m_val [2];

   logic [N-1:0] fire [2];
   int acc_cyc [$];
   int acc_id  [$];
   int stb_cyc [$];
   logic [5:0] stb_q [$];
   logic [W-1:0] val_q [$];
   int busy_cnt = 0;

   logic [W-1:0] exp_q [$];
   logic [5:0]   exp_s [$];
   int           exp_id [$];

   always #5 clk = ~clk;

   mouse_cmd_arbiter #(.N_REQ(N), .GAP(2), .VAL_W(W)) dut (
      .clk(clk), .rst(rst),
      .req_valid(rv[0]), .req_op(rop[0]), .req_value(rval[0]),
      .req_ready(rdy[0]), .value(dval[0]),
      .setmax_x(stb[0][0]), .setmax_y(stb[0][1]), .setmin_x(stb[0][2]),
      .setmin_y(stb[0][3]), .set_x(stb[0][4]), .set_y(stb[0][5]),
      .grant_id(gid[0]), .busy(dbusy[0]), .err_op(derr[0]), .state(dstate[0])
   );

   mouse_cmd_arbiter #(.N_REQ(N), .GAP(0), .VAL_W(W)) dut_g0 (
      .clk(clk), .rst(rst),
      .req_valid(rv[1]), .req_op(rop[1]), .req_value(rval[1]),
      .req_ready(rdy[1]), .value(dval[1]),
      .setmax_x(stb[1][0]), .setmax_y(stb[1][1]), .setmin_x(stb[1][2]),
      .setmin_y(stb[1][3]), .set_x(stb[1][4]), .set_y(stb[1][5]),
      .grant_id(gid[1]), .busy(dbusy[1]), .err_op(derr[1]), .state(dstate[1])
   );

   function automatic int gap_of(input int k);
      return (k == 0) ? 2 : 0;
   endfunction

   function automatic int pick(input int k);
      for (int j = 1; j <= N; j++) begin
         if (rv[k][(m_ptr[k] + j) % N]) return (m_ptr[k] + j) % N;
      end
      return -1;
   endfunction

   function automatic int oh_idx(input logic [N-1:0] f);
      for (int i = 0; i < N; i++) if (f[i]) return i;
      return -1;
   endfunction

   task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s[dut%0d] @cyc %0d: got %0d expected %0d", nm, k, cyc, act, exp);
      end
   endtask

   // model: one accept per idle cycle, then 1+GAP busy cycles, strobe only in the first
   always @(posedge clk) begin
      cyc++;
      for (int k = 0; k < 2; k++) begin
         if (rst) begin
            m_busy[k] = 0; m_ptr[k] = N - 1; m_gid[k] = 0;
            m_stb[k] = -1; m_err[k] = 1'b0; m_val[k] = '0;
         end else if (m_busy[k] > 0) begin
            m_busy[k]--;
            m_stb[k] = -1;
         end else begin
            int w;
            w = pick(k);
            m_stb[k] = -1;
            if (w >= 0) begin
               m_ptr[k] = w;
               m_gid[k] = w;
               if (rop[k][3*w +: 3] < 3'd6) begin
                  m_stb[k]  = int'(rop[k][3*w +: 3]);
                  m_val[k]  = rval[k][W*w +: W];
                  m_busy[k] = 1 + gap_of(k);
               end else begin
                  m_err[k] = 1'b1;
               end
            end
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         for (int k = 0; k < 2; k++) begin
            int w;
            logic [N-1:0] er;
            logic [5:0] es;
            w  = pick(k);
            er = '0;
            if (m_busy[k] == 0 && w >= 0) er[w] = 1'b1;
            es = '0;
            if (m_stb[k] >= 0) es[m_stb[k]] = 1'b1;
            chk("req_ready", k, rdy[k], er);
            chk("strobes", k, stb[k], es);
            chk("value", k, dval[k], m_val[k]);
            chk("grant_id", k, gid[k], m_gid[k]);
            chk("busy", k, dbusy[k], m_busy[k] > 0);
            chk("err_op", k, derr[k], m_err[k]);
         end
      end
   end

   always @(negedge clk) begin
      for (int k = 0; k < 2; k++) fire[k] = rv[k] & rdy[k];
      if (fire[lk] != '0) begin
         acc_cyc.push_back(cyc);
         acc_id.push_back(oh_idx(fire[lk]));
      end
      if (stb[lk] != 6'd0) begin
         stb_cyc.push_back(cyc);
         stb_q.push_back(stb[lk]);
         val_q.push_back(dval[lk]);
      end
      if (dbusy[lk]) busy_cnt++;
   end

   task automatic step();
      @(posedge clk);
      #1;
      for (int k = 0; k < 2; k++) rv[k] = rv[k] & ~fire[k];
   endtask

   task automatic clear_logs();
      acc_cyc.delete(); acc_id.delete(); stb_cyc.delete();
      stb_q.delete(); val_q.delete(); busy_cnt = 0;
      exp_q.delete(); exp_s.delete(); exp_id.delete();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      rv[0] = '0; rv[1] = '0;
      step(); step();
      rst = 1'b0;
      clear_logs();
   endtask

   task automatic set_req(input int k, input int i, input logic [2:0] op, input logic [W-1:0] val);
      rv[k][i] = 1'b1;
      rop[k][3*i +: 3] = op;
      rval[k][W*i +: W] = val;
   endtask

   task automatic timeout(input string nm);
      checks++;
      errors++;
      $display("FAIL %s: wait bound expired @cyc %0d", nm, cyc);
   endtask

   task automatic wait_acc(input int n, input string nm);
      int t;
      t = 0;
      while (acc_id.size() < n && t < 40) begin step(); t++; end
      if (acc_id.size() < n) timeout(nm);
   endtask

   task automatic drain(input int k, input string nm);
      int t;
      t = 0;
      while ((rv[k] != '0 || m_busy[k] != 0) && t < 60) begin step(); t++; end
      if (t >= 60) timeout(nm);
      repeat (2) step();
   endtask

   task automatic expect_cmd(input int id, input logic [5:0] s, input logic [W-1:0] v);
      exp_id.push_back(id);
      exp_s.push_back(s);
      exp_q.push_back(v);
   endtask

   task automatic check_seq(input string nm);
      chk({nm, " accepts"}, lk, acc_id.size(), exp_id.size());
      chk({nm, " strobes"}, lk, stb_q.size(), exp_s.size());
      foreach (exp_id[i]) if (i < acc_id.size()) chk({nm, " grant order"}, lk, acc_id[i], exp_id[i]);
      foreach (exp_s[i]) begin
         if (i < stb_q.size()) begin
            chk({nm, " strobe"}, lk, stb_q[i], exp_s[i]);
            chk({nm, " strobe value"}, lk, val_q[i], exp_q[i]);
         end
      end
   endtask

   initial begin
      rv[0] = '0; rv[1] = '0;
      rop[0] = '0; rop[1] = '0;
      rval[0] = '0; rval[1] = '0;
      do_reset();
      chk_en = 1'b1;
      @(negedge clk);
      chk("reset value", 0, dval[0], 0);
      chk("reset busy", 0, dbusy[0], 0);
      chk("reset ready", 0, rdy[0], 0);

      // single request
      lk = 0;
      set_req(0, 0, 3'd0, 12'd1019);
      drain(0, "single");
      expect_cmd(0, 6'b000001, 12'd1019);
      check_seq("single");
      if (acc_cyc.size() > 0 && stb_cyc.size() > 0)
         chk("single latency", 0, stb_cyc[0] - acc_cyc[0], 1);
      chk("single busy cycles", 0, busy_cnt, 3);

      // contention from reset
      do_reset();
      set_req(0, 0, 3'd4, 12'd511);
      set_req(0, 1, 3'd5, 12'd460);
      set_req(0, 2, 3'd2, 12'd361);
      drain(0, "contention");
      expect_cmd(0, 6'b010000, 12'd511);
      expect_cmd(1, 6'b100000, 12'd460);
      expect_cmd(2, 6'b000100, 12'd361);
      check_seq("contention");
      if (acc_cyc.size() == 3) begin
         chk("contention period a", 0, acc_cyc[1] - acc_cyc[0], 4);
         chk("contention period b", 0, acc_cyc[2] - acc_cyc[1], 4);
      end
      chk("contention last grant", 0, gid[0], 2);

      // round-robin wrap with two persistent requesters
      do_reset();
      set_req(0, 0, 3'd0, 12'd100);
      set_req(0, 2, 3'd1, 12'd200);
      begin
         int t;
         t = 0;
         while (acc_id.size() < 4 && t < 60) begin
            rv[0] = rv[0] | 3'b101;
            step();
            t++;
         end
         if (acc_id.size() < 4) timeout("wrap");
      end
      rv[0] = '0;
      drain(0, "wrap");
      expect_cmd(0, 6'b000001, 12'd100);
      expect_cmd(2, 6'b000010, 12'd200);
      expect_cmd(0, 6'b000001, 12'd100);
      expect_cmd(2, 6'b000010, 12'd200);
      check_seq("wrap");

      // illegal opcode, then a legal one from the same requester
      do_reset();
      set_req(0, 1, 3'd7, 12'd5);
      drain(0, "illegal");
      exp_id.push_back(1);
      check_seq("illegal");
      chk("illegal busy cycles", 0, busy_cnt, 0);
      chk("illegal err_op", 0, derr[0], 1);
      clear_logs();
      set_req(0, 1, 3'd3, 12'd367);
      drain(0, "after illegal");
      expect_cmd(1, 6'b001000, 12'd367);
      check_seq("after illegal");
      chk("err_op sticky", 0, derr[0], 1);
      do_reset();
      @(negedge clk);
      chk("err_op cleared", 0, derr[0], 0);

      // GAP=0 instance: back-to-back commands from req0
      lk = 1;
      do_reset();
      set_req(1, 0, 3'd0, 12'd10);
      wait_acc(1, "gap0 first");
      set_req(1, 0, 3'd1, 12'd20);
      drain(1, "gap0");
      expect_cmd(0, 6'b000001, 12'd10);
      expect_cmd(0, 6'b000010, 12'd20);
      check_seq("gap0");
      if (acc_cyc.size() == 2 && stb_cyc.size() == 2) begin
         chk("gap0 accept period", 1, acc_cyc[1] - acc_cyc[0], 2);
         chk("gap0 strobe spacing", 1, stb_cyc[1] - stb_cyc[0], 2);
         chk("gap0 latency", 1, stb_cyc[0] - acc_cyc[0], 1);
      end

      // reset during the first HOLD cycle
      lk = 0;
      do_reset();
      set_req(0, 2, 3'd6, 12'd9);
      wait_acc(1, "hold illegal");
      set_req(0, 1, 3'd0, 12'd55);
      wait_acc(2, "hold first");
      set_req(0, 1, 3'd1, 12'd77);
      set_req(0, 2, 3'd2, 12'd88);
      step();
      chk("hold busy before reset", 0, dbusy[0], 1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      clear_logs();
      @(negedge clk);
      chk("hold rst strobes", 0, stb[0], 0);
      chk("hold rst value", 0, dval[0], 0);
      chk("hold rst busy", 0, dbusy[0], 0);
      chk("hold rst err_op", 0, derr[0], 0);
      chk("hold rst grant_id", 0, gid[0], 0);
      drain(0, "hold resume");
      expect_cmd(1, 6'b000010, 12'd77);
      expect_cmd(2, 6'b000100, 12'd88);
      check_seq("hold resume");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

endmodule
